// File: rtl/tblink_rpc_call_pkg.sv
// Shared types for the RPC call queue: FSM states and the fixed-width part of a queued call.
package tblink_rpc_call_pkg;

  localparam int CALL_ID_W = 64;
  localparam int METHOD_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESPOND
  } call_state_e;

  // Fixed fields of a FIFO entry; the parameter payload is appended by the user of this type.
  typedef struct packed {
    logic [CALL_ID_W-1:0] call_id;
    logic [METHOD_W-1:0]  method;
    logic                 blocking;
  } call_hdr_t;

  localparam int CALL_HDR_W = $bits(call_hdr_t);

endpackage

// File: rtl/tblink_rpc_fifo_sync.sv
// Synchronous FIFO with registered storage; pushes are refused when full, pops when empty.
module tblink_rpc_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO never takes a push, even when a pop frees a slot in the same cycle.
  assign do_push = push && (count_q != FULL_CNT);
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/tblink_rpc_call_queue.sv
// Serialises RPC calls: queues requests, issues one command at a time, waits for completion, answers.
module tblink_rpc_call_queue
  import tblink_rpc_call_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PARAM_W = 32,
  parameter int RET_W   = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,

  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [CALL_ID_W-1:0]         req_call_id,
  input  logic [METHOD_W-1:0]          req_method,
  input  logic                         req_blocking,
  input  logic [PARAM_W-1:0]           req_param,

  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [METHOD_W-1:0]          cmd_method,
  output logic [PARAM_W-1:0]           cmd_param,

  input  logic                         done_valid,
  input  logic [RET_W-1:0]             done_retval,

  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [CALL_ID_W-1:0]         rsp_call_id,
  output logic [RET_W-1:0]             rsp_retval,

  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         err_done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    call_hdr_t          hdr;
    logic [PARAM_W-1:0] param;
  } call_entry_t;

  localparam int ENTRY_W = $bits(call_entry_t);

  call_state_e        state_q;
  call_state_e        state_d;
  call_entry_t        wr_entry;
  call_entry_t        head_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_push;
  logic               fifo_pop;
  logic               load_hold;
  logic               clear_retval;
  logic               capture_retval;
  logic               stray_done;

  call_hdr_t          hold_hdr;
  logic [PARAM_W-1:0] hold_param;
  logic [RET_W-1:0]   retval_q;
  logic               err_done_q;

  assign wr_entry.hdr.call_id  = req_call_id;
  assign wr_entry.hdr.method   = req_method;
  assign wr_entry.hdr.blocking = req_blocking;
  assign wr_entry.param        = req_param;

  assign req_ready = (fifo_count != FULL_CNT);
  assign fifo_push = req_valid && req_ready;

  tblink_rpc_fifo_sync #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (wr_entry),
    .pop     (fifo_pop),
    .rdata   (head_entry),
    .count   (fifo_count)
  );

  // Completions are only meaningful while a blocking call is waiting for one.
  assign stray_done = done_valid && (state_q != ST_WAIT_DONE);

  always_comb begin
    state_d        = state_q;
    fifo_pop       = 1'b0;
    load_hold      = 1'b0;
    clear_retval   = 1'b0;
    capture_retval = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop  = 1'b1;
          load_hold = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          if (hold_hdr.blocking) begin
            state_d = ST_WAIT_DONE;
          end else begin
            clear_retval = 1'b1;
            state_d      = ST_RESPOND;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (done_valid) begin
          capture_retval = 1'b1;
          state_d        = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_hdr   <= '0;
      hold_param <= '0;
      retval_q   <= '0;
      err_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_hold) begin
        hold_hdr   <= head_entry.hdr;
        hold_param <= head_entry.param;
      end
      if (clear_retval) begin
        retval_q <= '0;
      end else if (capture_retval) begin
        retval_q <= done_retval;
      end
      if (stray_done) err_done_q <= 1'b1;
    end
  end

  // All handshake outputs come straight from registers, so payloads hold while stalled.
  assign cmd_valid   = (state_q == ST_ISSUE);
  assign cmd_method  = hold_hdr.method;
  assign cmd_param   = hold_param;
  assign rsp_valid   = (state_q == ST_RESPOND);
  assign rsp_call_id = hold_hdr.call_id;
  assign rsp_retval  = retval_q;
  assign count       = fifo_count;
  assign busy        = (state_q != ST_IDLE);
  assign err_done    = err_done_q;

endmodule

// File: doc/tblink_rpc_call_queue.md
TBLINK_RPC_CALL_QUEUE -- requirements
Module: tblink_rpc_call_queue

Interface
REQ-001 The block SHALL provide these parameters:
- DEPTH, default 4: request FIFO entries; power of two, at least 2.
- PARAM_W, default 32: width of the call parameter payload.
- RET_W, default 32: width of the return value.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset. Ports are listed as name, direction, width, meaning.
- clock, in, 1: the single clock.
- reset_n, in, 1: asynchronous active-low reset.
REQ-003 Request side, written by the DPI invoke path:
- req_valid, in, 1: request present.
- req_ready, out, 1: FIFO can accept.
- req_call_id, in, 64: caller's call id.
- req_method, in, 16: method index.
- req_blocking, in, 1: 1 = blocking method.
- req_param, in, PARAM_W: call parameters.
REQ-004 Command side, toward the DUT BFM:
- cmd_valid, out, 1: command present.
- cmd_ready, in, 1: BFM accepts command.
- cmd_method, out, 16: method index.
- cmd_param, out, PARAM_W: call parameters.
REQ-005 Completion side, from the DUT BFM:
- done_valid, in, 1: one-cycle completion pulse.
- done_retval, in, RET_W: return value.
REQ-006 Response side, toward invoke_rsp:
- rsp_valid, out, 1: response present.
- rsp_ready, in, 1: consumer accepts.
- rsp_call_id, out, 64: call id being answered.
- rsp_retval, out, RET_W: return value.
REQ-007 Status outputs:
- count, out, $clog2(DEPTH+1): FIFO occupancy.
- busy, out, 1: FSM not in IDLE.
- err_done, out, 1: sticky flag, set by an unexpected completion.

Function
REQ-008 The request FIFO SHALL store {call_id, method, blocking, param} in order.
- req_ready = (count != DEPTH).
- A push occurs on req_valid && req_ready.
- When full, no push is taken even if a pop happens in the same cycle.
REQ-009 The FSM SHALL have four states: IDLE, ISSUE, WAIT_DONE, RESPOND.
REQ-010 IDLE: when count != 0, pop the head into holding registers and go to ISSUE on the next cycle.
REQ-011 ISSUE: assert cmd_valid from the holding registers.
- On cmd_valid && cmd_ready, go to WAIT_DONE if blocking, otherwise go to RESPOND with the retval register cleared to 0.
REQ-012 WAIT_DONE: on done_valid, capture done_retval and go to RESPOND.
REQ-013 RESPOND: assert rsp_valid with the held call_id and retval; on rsp_ready, go to IDLE.
REQ-014 cmd_valid and rsp_valid SHALL come only from registered state.
- While valid is high and ready is low, each SHALL stay asserted and its payload SHALL stay stable.
REQ-015 Latency: a request pushed at cycle N into an empty FIFO while in IDLE SHALL produce cmd_valid at cycle N+2.
- For a non-blocking call with cmd_ready=1, rsp_valid SHALL be high at N+3.
REQ-016 Exactly one call SHALL be in flight. Later requests stay queued until RESPOND completes.
REQ-017 A done_valid pulse in any state other than WAIT_DONE SHALL be ignored and SHALL set err_done. err_done is cleared only by reset.
REQ-018 A push and a pop in the same cycle SHALL leave count unchanged. Read and write pointers SHALL wrap modulo DEPTH.
REQ-019 busy SHALL be high in ISSUE, WAIT_DONE and RESPOND.

Reset
REQ-020 While reset_n is low, the block SHALL hold:
- FSM in IDLE; FIFO pointers and count at 0.
- req_ready = 1.
- cmd_valid, rsp_valid, busy and err_done at 0.
- Holding registers and retval at 0.
REQ-021 Reset asserted mid-call SHALL discard the in-flight call and all queued entries, with no response issued.
- After release, the first new request follows REQ-015 timing.

Structure
REQ-022 Package tblink_rpc_call_pkg SHALL contain:
- the FSM state enum;
- CALL_ID_W = 64 and METHOD_W = 16;
- the packed FIFO entry struct type.
REQ-023 Storage SHALL be one sub-module, tblink_rpc_fifo_sync (parameterised width and depth, registered storage).
- The FSM and holding registers live in tblink_rpc_call_queue.

Verification
REQ-024 Non-blocking call: push call_id=0x10, method=3, param=0xAB, blocking=0; keep cmd_ready=1 and rsp_ready=1.
- Required: cmd_valid at N+2 with method 3 and param 0xAB.
- Required: rsp_valid at N+3 with call_id 0x10 and retval 0.
REQ-025 Blocking call: push call_id=7, blocking=1; pulse done_valid with retval 0x55 five cycles after the cmd handshake.
- Required: rsp_valid the cycle after done, with call_id 7 and retval 0x55.
REQ-026 Back-pressure and full: hold cmd_ready=0 and push DEPTH+2 requests.
- Required: req_ready drops when count reaches DEPTH (one entry is already in the holding registers).
- Required: after releasing cmd_ready, all calls complete in order and call_ids match.
REQ-027 Stray completion: pulse done_valid while in IDLE.
- Required: err_done=1, and no state change or response.
REQ-028 Reset mid-operation: assert reset_n low while in WAIT_DONE with 2 entries queued.
- Required: count=0, all valids low, and rsp_valid is never asserted for the discarded calls.
